dm_bus_arbiter: RTL and testbench

Shares the debug module's single hart-side bus slave port between NUM_HART hart bus masters. Each master runs debug ROM fetches, dm_request polling, data0/data1 accesses and halt/resume notifications through this port. The arbiter uses round-robin selection, holds one transaction at a time, and forwards the granted master's request to the debug module unchanged. It sits between the per-hart debug bus ports and the debug module bus port in the debug subsystem top.

---
 rtl/dm_bus_arbiter_pkg.sv | 30 +++
 rtl/dm_bus_arbiter_if.sv | 27 ++
 rtl/dm_rr_pick.sv | 36 +++
 rtl/dm_bus_arbiter.sv | 104 ++++++++++
 tb/tb_dm_bus_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/dm_bus_arbiter_pkg.sv
// Shared debug-bus definitions: widths, hart-side word addresses and the arbiter
// state encoding used by the debug module bus arbiter.
package dm_bus_arbiter_pkg;

  localparam int DM_BUS_ADDR_W = 18;
  localparam int DM_BUS_DATA_W = 32;
  localparam int GRANT_ID_W    = 4;
  localparam int MAX_HART      = 1 << GRANT_ID_W;

  // Word addresses (byte address >> 2) of the hart-side debug module registers
  localparam logic [DM_BUS_ADDR_W-1:0] BUS_ADDR_DM_REQUEST  = 18'h00000;
  localparam logic [DM_BUS_ADDR_W-1:0] BUS_ADDR_DATA0       = 18'h00004;
  localparam logic [DM_BUS_ADDR_W-1:0] BUS_ADDR_DATA1       = 18'h00005;
  localparam logic [DM_BUS_ADDR_W-1:0] BUS_ADDR_CORE_HALT   = 18'h00008;
  localparam logic [DM_BUS_ADDR_W-1:0] BUS_ADDR_CORE_RESUME = 18'h00009;
  localparam logic [DM_BUS_ADDR_W-1:0] BUS_ADDR_ROM_BASE    = 18'h00040;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } arb_state_e;

  // Round-robin successor of a grant index, wrapping at the number of masters.
  function automatic logic [GRANT_ID_W-1:0] rr_next(input logic [GRANT_ID_W-1:0] id,
                                                    input int unsigned n);
    if (32'(id) + 32'd1 >= n) return '0;
    return id + 1'b1;
  endfunction

endpackage

// File: rtl/dm_bus_arbiter_if.sv
// Debug bus bundle; NUM_PORT > 1 packs several masters side by side
// (port i at [i*ADDR_W +: ADDR_W] and [i*32 +: 32]), read data is shared.
interface dm_bus_arbiter_if
  import dm_bus_arbiter_pkg::*;
#(
  parameter int NUM_PORT = 1,
  parameter int ADDR_W   = DM_BUS_ADDR_W
) ();

  logic [NUM_PORT-1:0]               valid;
  logic [NUM_PORT-1:0]               ready;
  logic [NUM_PORT-1:0]               write;
  logic [NUM_PORT*ADDR_W-1:0]        addr;
  logic [NUM_PORT*DM_BUS_DATA_W-1:0] wdata;
  logic [DM_BUS_DATA_W-1:0]          rdata;

  modport master (
    output valid, write, addr, wdata,
    input  ready, rdata
  );

  modport slave (
    input  valid, write, addr, wdata,
    output ready, rdata
  );

endinterface

// File: rtl/dm_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping modulo NUM_REQ, found by searching a doubled request vector.
module dm_rr_pick
  import dm_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [GRANT_ID_W-1:0] ptr_i,
  output logic [GRANT_ID_W-1:0] idx_o,
  output logic                  any_o
);

  localparam int DBL_W = 2 * NUM_REQ;

  logic [DBL_W-1:0] dbl;
  logic [DBL_W-1:0] mask;
  int unsigned      pos;

  always_comb begin
    dbl   = {req_i, req_i};
    mask  = '0;
    pos   = 0;
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      pos  = 32'(ptr_i) + j;
      mask = DBL_W'(1) << pos;
      if (!any_o && |(dbl & mask)) begin
        any_o = 1'b1;
        idx_o = GRANT_ID_W'((pos >= NUM_REQ) ? pos - NUM_REQ : pos);
      end
    end
  end

endmodule

// File: rtl/dm_bus_arbiter.sv
// Round-robin arbiter sharing the debug module hart-side bus slave between
// NUM_HART hart masters, one transaction in flight at a time.
module dm_bus_arbiter
  import dm_bus_arbiter_pkg::*;
#(
  parameter int NUM_HART = 2,
  parameter int ADDR_W   = DM_BUS_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  dm_bus_arbiter_if.slave       m_bus,
  dm_bus_arbiter_if.master      bus,
  output logic [GRANT_ID_W-1:0] grant_id,
  output logic                  busy
);

  arb_state_e            state_q, state_d;
  logic [GRANT_ID_W-1:0] grant_q, grant_d;
  logic [GRANT_ID_W-1:0] rr_q, rr_d;
  logic [GRANT_ID_W-1:0] pick_idx;
  logic                  pick_any;
  logic                  done;

  // Full-depth mux tables indexed directly by grant_q; slots beyond NUM_HART read 0
  logic [MAX_HART-1:0]      valid_tab;
  logic [MAX_HART-1:0]      write_tab;
  logic [ADDR_W-1:0]        addr_tab  [MAX_HART];
  logic [DM_BUS_DATA_W-1:0] wdata_tab [MAX_HART];

  for (genvar g = 0; g < MAX_HART; g++) begin : g_tab
    if (g < NUM_HART) begin : g_used
      assign valid_tab[g] = m_bus.valid[g];
      assign write_tab[g] = m_bus.write[g];
      assign addr_tab[g]  = m_bus.addr[g*ADDR_W +: ADDR_W];
      assign wdata_tab[g] = m_bus.wdata[g*DM_BUS_DATA_W +: DM_BUS_DATA_W];
    end else begin : g_tie
      assign valid_tab[g] = 1'b0;
      assign write_tab[g] = 1'b0;
      assign addr_tab[g]  = '0;
      assign wdata_tab[g] = '0;
    end
  end

  dm_rr_pick #(
    .NUM_REQ (NUM_HART)
  ) u_pick (
    .req_i (m_bus.valid),
    .ptr_i (rr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign done = (state_q == ST_BUSY) && bus.valid && bus.ready;

  for (genvar g = 0; g < NUM_HART; g++) begin : g_ready
    assign m_bus.ready[g] = done && (grant_q == GRANT_ID_W'(g));
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    bus.valid = 1'b0;
    bus.write = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A master dropping valid mid-transaction is still forwarded as-is
        bus.valid = valid_tab[grant_q];
        bus.write = write_tab[grant_q];
        bus.addr  = addr_tab[grant_q];
        bus.wdata = wdata_tab[grant_q];
        if (bus.valid && bus.ready) begin
          rr_d    = rr_next(grant_q, NUM_HART);
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  assign m_bus.rdata = bus.rdata;
  assign grant_id    = grant_q;
  assign busy        = (state_q == ST_BUSY);

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Directed bench for dm_bus_arbiter: a two-hart build plus a single-hart build,
// each driving a small debug-module responder model.
`timescale 1ns/1ps
module tb_dm_bus_arbiter;
  import dm_bus_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  int errors = 0;
  int checks = 0;

  dm_bus_arbiter_if #(.NUM_PORT(2), .ADDR_W(DM_BUS_ADDR_W)) hb2 ();
  dm_bus_arbiter_if #(.NUM_PORT(1), .ADDR_W(DM_BUS_ADDR_W)) db2 ();
  dm_bus_arbiter_if #(.NUM_PORT(1), .ADDR_W(DM_BUS_ADDR_W)) hb1 ();
  dm_bus_arbiter_if #(.NUM_PORT(1), .ADDR_W(DM_BUS_ADDR_W)) db1 ();

  logic [GRANT_ID_W-1:0] gid2, gid1;
  logic                  busy2, busy1;

  dm_bus_arbiter #(.NUM_HART(2), .ADDR_W(DM_BUS_ADDR_W)) dut2 (
    .clk(clk), .reset(reset), .m_bus(hb2), .bus(db2), .grant_id(gid2), .busy(busy2)
  );

  dm_bus_arbiter #(.NUM_HART(1), .ADDR_W(DM_BUS_ADDR_W)) dut1 (
    .clk(clk), .reset(reset), .m_bus(hb1), .bus(db1), .grant_id(gid1), .busy(busy1)
  );

  // Responder for the two-hart build: ROM word at the ROM base, else the address echoed
  always_ff @(posedge clk) begin
    if (reset) db2.ready <= 1'b0;
    else       db2.ready <= db2.valid && !db2.ready;
  end
  assign db2.rdata = (db2.addr == BUS_ADDR_ROM_BASE) ? 32'h0010_0073 : {14'h0, db2.addr};

  // Responder for the single-hart build: 16-word memory
  logic [31:0] mem1 [16];
  always_ff @(posedge clk) begin
    if (reset) begin
      db1.ready <= 1'b0;
      for (int i = 0; i < 16; i++) mem1[i] <= 32'h1111_1111 * 32'(i);
    end else begin
      db1.ready <= db1.valid && !db1.ready;
      if (db1.valid && db1.ready && db1.write) mem1[db1.addr[3:0]] <= db1.wdata;
    end
  end
  assign db1.rdata = mem1[db1.addr[3:0]];

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req2(input bit m, input logic wr, input logic [17:0] a, input logic [31:0] d);
    if (m) begin
      hb2.valid[1] = 1'b1; hb2.write[1] = wr; hb2.addr[35:18] = a; hb2.wdata[63:32] = d;
    end else begin
      hb2.valid[0] = 1'b1; hb2.write[0] = wr; hb2.addr[17:0] = a; hb2.wdata[31:0] = d;
    end
  endtask

  task automatic drop2(input bit m);
    if (m) hb2.valid[1] = 1'b0;
    else   hb2.valid[0] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    hb2.valid = '0; hb2.write = '0; hb2.addr = '0; hb2.wdata = '0;
    hb1.valid = '0; hb1.write = '0; hb1.addr = '0; hb1.wdata = '0;
    nxt();
    nxt();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] shadow [16];
  logic        wr;
  logic [17:0] a;
  logic [31:0] d;
  int          exp_rdy;

  initial begin
    // T1: single read of the ROM base by master 0
    do_reset();
    reset = 1'b0;
    req2(0, 1'b0, BUS_ADDR_ROM_BASE, 32'h0);
    #1;
    chk("rst_busy", 32'(busy2), 0);
    chk("rst_grant", 32'(gid2), 0);
    chk("rst_bus_valid", 32'(db2.valid), 0);
    chk("rst_m_ready", 32'(hb2.ready), 0);
    nxt(); #1;
    chk("t1_c1_bus_valid", 32'(db2.valid), 1);
    chk("t1_c1_busy", 32'(busy2), 1);
    chk("t1_c1_grant", 32'(gid2), 0);
    chk("t1_c1_addr", 32'(db2.addr), 32'h40);
    chk("t1_c1_m_ready", 32'(hb2.ready), 0);
    nxt(); #1;
    chk("t1_c2_m_ready", 32'(hb2.ready), 1);
    chk("t1_c2_rdata", hb2.rdata, 32'h0010_0073);
    chk("t1_c2_busy", 32'(busy2), 1);
    nxt(); drop2(0); #1;
    chk("t1_c3_busy", 32'(busy2), 0);
    chk("t1_c3_m_ready", 32'(hb2.ready), 0);

    // T2: both masters hold requests from reset -> grants 0,1,0,1
    do_reset();
    reset = 1'b0;
    req2(0, 1'b0, BUS_ADDR_DM_REQUEST, 32'h0);
    req2(1, 1'b0, BUS_ADDR_DATA0, 32'h0);
    for (int c = 0; c < 12; c++) begin
      #1;
      exp_rdy = (c == 2 || c == 8) ? 1 : (c == 5 || c == 11) ? 2 : 0;
      chk($sformatf("t2_m_ready_c%0d", c), 32'(hb2.ready), 32'(exp_rdy));
      chk($sformatf("t2_busy_c%0d", c), 32'(busy2), (c % 3 != 0) ? 1 : 0);
      if (c % 3 == 1) begin
        chk($sformatf("t2_grant_c%0d", c), 32'(gid2), (c == 1 || c == 7) ? 0 : 1);
        chk($sformatf("t2_addr_c%0d", c), 32'(db2.addr),
            (c == 1 || c == 7) ? 32'(BUS_ADDR_DM_REQUEST) : 32'(BUS_ADDR_DATA0));
      end
      nxt();
    end
    drop2(0); drop2(1);

    // T3: master 1 writes the core-halt register while master 0 is idle
    do_reset();
    reset = 1'b0;
    req2(1, 1'b1, BUS_ADDR_CORE_HALT, 32'h1);
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("t3_m0_ready_c%0d", c), 32'(hb2.ready[0]), 0);
      if (c == 1) begin
        chk("t3_bus_valid", 32'(db2.valid), 1);
        chk("t3_bus_write", 32'(db2.write), 1);
        chk("t3_bus_addr", 32'(db2.addr), 32'(BUS_ADDR_CORE_HALT));
        chk("t3_bus_wdata", db2.wdata, 32'h1);
        chk("t3_grant", 32'(gid2), 1);
      end
      if (c == 2) chk("t3_m_ready", 32'(hb2.ready), 2);
      nxt();
      if (c == 2) drop2(1);
    end

    // T4: master 0 re-requests in its own IDLE cycle while master 1 waits
    do_reset();
    reset = 1'b0;
    req2(0, 1'b0, BUS_ADDR_DATA1, 32'h0);
    nxt(); req2(1, 1'b0, BUS_ADDR_CORE_RESUME, 32'h0); #1;
    chk("t4_c1_grant", 32'(gid2), 0);
    nxt(); #1;
    chk("t4_c2_m_ready", 32'(hb2.ready), 1);
    nxt(); req2(0, 1'b0, BUS_ADDR_DM_REQUEST, 32'h0); #1;
    chk("t4_c3_busy", 32'(busy2), 0);
    nxt(); #1;
    chk("t4_c4_grant", 32'(gid2), 1);
    chk("t4_c4_addr", 32'(db2.addr), 32'(BUS_ADDR_CORE_RESUME));
    nxt(); #1;
    chk("t4_c5_m_ready", 32'(hb2.ready), 2);
    nxt(); drop2(1); #1;
    chk("t4_c6_busy", 32'(busy2), 0);
    nxt(); #1;
    chk("t4_c7_grant", 32'(gid2), 0);
    chk("t4_c7_addr", 32'(db2.addr), 32'(BUS_ADDR_DM_REQUEST));
    nxt(); #1;
    chk("t4_c8_m_ready", 32'(hb2.ready), 1);
    nxt(); drop2(0);

    // T5: reset lands in the cycle bus_valid rises
    do_reset();
    reset = 1'b0;
    req2(0, 1'b0, BUS_ADDR_DATA0, 32'h0);
    nxt(); #1;
    chk("t5_c1_bus_valid", 32'(db2.valid), 1);
    reset = 1'b1;
    req2(1, 1'b0, BUS_ADDR_DATA1, 32'h0);
    nxt(); #1;
    chk("t5_c2_bus_valid", 32'(db2.valid), 0);
    chk("t5_c2_busy", 32'(busy2), 0);
    chk("t5_c2_grant", 32'(gid2), 0);
    chk("t5_c2_m_ready", 32'(hb2.ready), 0);
    reset = 1'b0;
    drop2(0);
    nxt(); #1;
    chk("t5_c3_grant", 32'(gid2), 1);
    chk("t5_c3_bus_valid", 32'(db2.valid), 1);
    chk("t5_c3_addr", 32'(db2.addr), 32'(BUS_ADDR_DATA1));
    nxt(); #1;
    chk("t5_c4_m_ready", 32'(hb2.ready), 2);
    nxt(); drop2(1);

    // T6: single-hart build, random reads/writes, fixed 2-cycle completion
    do_reset();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) shadow[i] = 32'h1111_1111 * 32'(i);
    for (int n = 0; n < 100; n++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 18'($urandom_range(0, 15));
      d  = $urandom;
      hb1.valid = 1'b1; hb1.write = wr; hb1.addr = a; hb1.wdata = d;
      #1;
      chk($sformatf("t6_n%0d_c0_ready", n), 32'(hb1.ready), 0);
      nxt(); #1;
      chk($sformatf("t6_n%0d_c1_ready", n), 32'(hb1.ready), 0);
      chk($sformatf("t6_n%0d_c1_bus_valid", n), 32'(db1.valid), 1);
      chk($sformatf("t6_n%0d_c1_addr", n), 32'(db1.addr), 32'(a));
      chk($sformatf("t6_n%0d_c1_grant", n), 32'(gid1), 0);
      nxt(); #1;
      chk($sformatf("t6_n%0d_c2_ready", n), 32'(hb1.ready), 1);
      if (wr) shadow[a[3:0]] = d;
      else    chk($sformatf("t6_n%0d_rdata", n), hb1.rdata, shadow[a[3:0]]);
      nxt();
    end
    hb1.valid = 1'b0;
    #1;
    chk("t6_end_busy", 32'(busy1), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
